// File: rtl/config_loader.sv
`timescale 1ns / 1ps
// Serial configuration writer: fetches NUM_WORDS words from a registered ROM and
// shifts them LSB-first onto the config chain, then pulses cfg_latch to commit.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 5,
    parameter int ADDR_W    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic              cfg_data,
    output logic              cfg_shift_en,
    output logic              cfg_latch,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_idx
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_word_idx;

    logic              r_shift_en;
    logic              r_latch;
    logic              r_busy;
    logic              r_done;

    logic              w_last_bit;
    logic              w_last_word;

    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_last_word = (r_word_idx == LAST_WORD);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: begin
                if (w_last_bit) begin
                    w_next = w_last_word ? S_LATCH : S_FETCH;
                end
            end
            S_LATCH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address, word index, shift register and bit counter advance with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_word_idx <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rom_addr <= '0;
                        r_word_idx <= '0;
                    end
                end
                S_LOAD: begin
                    r_shift   <= rom_data;
                    r_bit_cnt <= '0;
                end
                S_SHIFT: begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_last_bit && !w_last_word) begin
                        r_word_idx <= r_word_idx + ADDR_W'(1);
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs are decoded from the next state and registered, so they are
    // flop outputs that track the current state without combinational glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift_en <= 1'b0;
            r_latch    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_shift_en <= (w_next == S_SHIFT);
            r_latch    <= (w_next == S_LATCH);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
        end
    end

    // The shift register drains to zero, so bit 0 is low outside SHIFT.
    assign cfg_data     = r_shift[0];
    assign cfg_shift_en = r_shift_en;
    assign cfg_latch    = r_latch;
    assign busy         = r_busy;
    assign done         = r_done;
    assign rom_addr     = r_rom_addr;
    assign word_idx     = r_word_idx;

endmodule
